cla16_sub_pipe: RTL and testbench

//  Pipelined WIDTH-bit lookahead subtractor: D = A - B - Bin. It is the inverse operation of the 16-bit CLA adder.

---
 rtl/cla16_sub_pipe_if.sv | 30 +++
 rtl/cla16_sub_pipe.sv | 140 ++++++++++++++
 tb/tb_cla16_sub_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla16_sub_pipe_if.sv
// Streaming handshake bundle for the pipelined lookahead subtractor.
// master drives operands and out_ready; slave returns the difference and status flags.
interface cla16_sub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             OV;
    logic             Z;
    logic             N;
    logic             GG;
    logic             PG;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, OV, Z, N, GG, PG
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, OV, Z, N, GG, PG
    );
endinterface

// File: rtl/cla16_sub_pipe.sv
// Two-stage lookahead subtractor D = A - B - Bin, computed as A + ~B + ~Bin.
// Stage 1 resolves the low group and its carry; stage 2 resolves the high group and flags.
module cla16_sub_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    cla16_sub_pipe_if.slave bus
);
    localparam int unsigned H = WIDTH / 2;

    typedef struct packed {
        logic         g;
        logic         p;
        logic         cout;
        logic [H-1:0] s;
    } grp_t;

    // One lookahead group: per-bit generate/propagate, carries, group G/P (carry-in independent).
    function automatic grp_t cla_group(input logic [H-1:0] a, input logic [H-1:0] nb,
                                       input logic cin);
        grp_t         r;
        logic [H-1:0] g;
        logic [H-1:0] p;
        logic [H:0]   c;
        g    = a & nb;
        p    = a ^ nb;
        c    = '0;
        c[0] = cin;
        r.g  = 1'b0;
        r.p  = 1'b1;
        for (int unsigned i = 0; i < H; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            r.g    = g[i] | (p[i] & r.g);
            r.p    = r.p & p[i];
        end
        r.cout = c[H];
        r.s    = p ^ c[H-1:0];
        return r;
    endfunction

    logic             s1_valid_q;
    logic [H-1:0]     s1_dlo_q;
    logic             s1_c_q;
    logic             s1_glo_q;
    logic             s1_plo_q;
    logic [H-1:0]     s1_ahi_q;
    logic [H-1:0]     s1_nbhi_q;
    logic             s1_amsb_q;
    logic             s1_bmsb_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ov_q;
    logic             z_q;
    logic             n_q;
    logic             gg_q;
    logic             pg_q;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    grp_t             lo;
    grp_t             hi;
    logic [WIDTH-1:0] d_next;

    always_comb begin
        s2_adv = !out_valid_q || bus.out_ready;
        s1_adv = s1_valid_q && s2_adv;
        accept = bus.in_valid && (!s1_valid_q || s2_adv);
    end

    assign lo     = cla_group(bus.A[H-1:0], ~bus.B[H-1:0], ~bus.Bin);
    assign hi     = cla_group(s1_ahi_q, s1_nbhi_q, s1_c_q);
    assign d_next = {hi.s, s1_dlo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_dlo_q   <= '0;
            s1_c_q     <= 1'b0;
            s1_glo_q   <= 1'b0;
            s1_plo_q   <= 1'b0;
            s1_ahi_q   <= '0;
            s1_nbhi_q  <= '0;
            s1_amsb_q  <= 1'b0;
            s1_bmsb_q  <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_dlo_q   <= lo.s;
            s1_c_q     <= lo.cout;
            s1_glo_q   <= lo.g;
            s1_plo_q   <= lo.p;
            s1_ahi_q   <= bus.A[WIDTH-1:H];
            s1_nbhi_q  <= ~bus.B[WIDTH-1:H];
            s1_amsb_q  <= bus.A[WIDTH-1];
            s1_bmsb_q  <= bus.B[WIDTH-1];
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Output data only moves when stage 1 advances, so a stalled result stays bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ov_q        <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            gg_q        <= 1'b0;
            pg_q        <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
            end
            if (s1_adv) begin
                d_q    <= d_next;
                bout_q <= ~hi.cout;
                ov_q   <= (s1_amsb_q != s1_bmsb_q) && (d_next[WIDTH-1] != s1_amsb_q);
                z_q    <= (d_next == '0);
                n_q    <= d_next[WIDTH-1];
                gg_q   <= hi.g | (hi.p & s1_glo_q);
                pg_q   <= hi.p & s1_plo_q;
            end
        end
    end

    assign bus.in_ready  = !s1_valid_q || s2_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.OV        = ov_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.GG        = gg_q;
    assign bus.PG        = pg_q;
endmodule

// File: tb/tb_cla16_sub_pipe.sv
// Scoreboard bench for cla16_sub_pipe: directed vectors with hand-computed results,
// checked in acceptance order by an independent output monitor.
module tb_cla16_sub_pipe;
    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        ov;
        logic        z;
        logic        n;
        logic        gg;
        logic        pg;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cla16_sub_pipe_if #(.WIDTH(16)) bus ();

    cla16_sub_pipe #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t vec [13];
    res_t exp_q [$];
    res_t mon_act;
    res_t mon_exp;
    res_t snap;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    int   n_pop = 0;
    int   base_acc;
    int   base_pop;

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                input logic [15:0] d, input logic bout, input logic ov,
                                input logic z, input logic n, input logic gg, input logic pg);
        vec_t v;
        v.a = a; v.b = b; v.bin = bin;
        v.r.d = d; v.r.bout = bout; v.r.ov = ov; v.r.z = z; v.r.n = n; v.r.gg = gg; v.r.pg = pg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic res_t cur_out();
        res_t r;
        r.d = bus.D; r.bout = bus.Bout; r.ov = bus.OV; r.z = bus.Z; r.n = bus.N;
        r.gg = bus.GG; r.pg = bus.PG;
        return r;
    endfunction

    // Drive one op (from a posedge+1 point) and hold it until the DUT accepts it.
    task automatic offer(input int idx);
        bus.in_valid = 1'b1;
        bus.A        = vec[idx].a;
        bus.B        = vec[idx].b;
        bus.Bin      = vec[idx].bin;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(vec[idx].r);
                n_acc++;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: op %0d got no in_ready, want accept within 50 cycles", idx);
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            mon_act = cur_out();
            n_cmp++;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got d=%h flags=%b, want no result", mon_act.d,
                         mon_act[5:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL result: got d=%h bout/ov/z/n/gg/pg=%b, want d=%h %b",
                             mon_act.d, mon_act[5:0], mon_exp.d, mon_exp[5:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          a         b         bin   d         bout ov z n gg pg
        vec[0]  = mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 0, 1, 0, 0);
        vec[1]  = mk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0, 0, 1, 0);
        vec[2]  = mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1, 1, 0, 1, 0, 0);
        vec[3]  = mk(16'h0100, 16'h0001, 1'b0, 16'h00FF, 0, 0, 0, 0, 1, 0);
        vec[4]  = mk(16'h1234, 16'h1233, 1'b1, 16'h0000, 0, 0, 1, 0, 1, 0);
        vec[5]  = mk(16'h5555, 16'h5555, 1'b0, 16'h0000, 0, 0, 1, 0, 0, 1);
        vec[6]  = mk(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 0, 0, 0, 1, 1, 0);
        vec[7]  = mk(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1, 0, 0, 1, 0, 1);
        vec[8]  = mk(16'h0003, 16'h0001, 1'b0, 16'h0002, 0, 0, 0, 0, 1, 0);
        vec[9]  = mk(16'h0010, 16'h0020, 1'b1, 16'hFFEF, 1, 0, 0, 1, 0, 0);
        vec[10] = mk(16'hABCD, 16'h1234, 1'b0, 16'h9999, 0, 0, 0, 1, 1, 0);
        vec[11] = mk(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1, 0, 0, 1, 0, 1);
        vec[12] = mk(16'h0005, 16'h0003, 1'b0, 16'h0002, 0, 0, 0, 0, 1, 0);

        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset_D", {16'b0, bus.D}, 32'd0);
        check("reset_flags", {26'b0, bus.Bout, bus.OV, bus.Z, bus.N, bus.GG, bus.PG}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", {31'b0, bus.in_ready}, 32'd1);

        // Latency: the accept edge loads stage 1, the next edge presents the result.
        offer(0);
        check("lat_first_edge_out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_second_edge_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("lat_second_edge_D", {16'b0, bus.D}, 32'h0000FFFF);

        // Full-rate stream with out_ready held high.
        for (int i = 1; i < 8; i++) offer(i);
        repeat (4) @(posedge clk);
        #1;
        check("stream_drained", exp_q.size(), 32'd0);
        check("idle_out_valid_clear", {31'b0, bus.out_valid}, 32'd0);

        // Backpressure: only two ops fit, output holds, then all four drain 1/cycle.
        bus.out_ready = 1'b0;
        base_acc      = n_acc;
        offer(8);
        offer(9);
        fork
            begin
                offer(10);
                offer(11);
            end
            begin
                repeat (4) @(negedge clk);
                #2;
                check("bp_accepted", n_acc - base_acc, 32'd2);
                check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
                check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
                snap = cur_out();
                repeat (3) @(negedge clk);
                #2;
                check("bp_hold_stable", {10'b0, cur_out()}, {10'b0, snap});
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                base_pop      = n_pop;
                repeat (4) @(negedge clk);
                #2;
                check("bp_drain_rate", n_pop - base_pop, 32'd4);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", exp_q.size(), 32'd0);

        // Reset with two ops in flight: they must vanish.
        bus.out_ready = 1'b0;
        offer(2);
        offer(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_D", {16'b0, bus.D}, 32'd0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_no_stale", {31'b0, bus.out_valid}, 32'd0);
        offer(12);
        check("post_rst_lat_first", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_lat_second", {31'b0, bus.out_valid}, 32'd1);
        check("post_rst_D", {16'b0, bus.D}, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
